// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared FSM encoding and defaults for the CPU data memory controller
package cpu_mem_pkg;

   localparam int DEF_DEPTH_WORDS  = 256;
   localparam int DEF_READ_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage: synchronous write, combinational read
module dmem_array #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU data port controller with fixed read latency and request checking
module data_mem_ctrl
   import cpu_mem_pkg::*;
#(
   parameter int DEPTH_WORDS  = DEF_DEPTH_WORDS,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_in,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] data_out,
   output logic        mem_ready,
   output logic        addr_err
);

   localparam int         AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [2:0] WAIT_CYCLES = 3'(READ_LATENCY - 1);

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          err_q, err_d;
   logic [31:0]   data_out_q, data_out_d;

   logic          req, legal, in_range, accept_rd, we;
   logic [AW-1:0] word_idx, raddr;
   logic [31:0]   rdata;

   assign req       = mem_read | mem_write;
   assign in_range  = {2'b00, data_addr[31:2]} < 32'(DEPTH_WORDS);
   assign legal     = (mem_read ^ mem_write) && (data_addr[1:0] == 2'b00) && in_range;
   assign word_idx  = data_addr[AW+1:2];
   assign accept_rd = (state_q == IDLE) && legal && mem_read;
   assign we        = (state_q == IDLE) && legal && mem_write && !rst;
   // Read port follows the live address while idle, the captured one afterwards.
   assign raddr     = (state_q == IDLE) ? word_idx : addr_q;

   dmem_array #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (word_idx),
      .wdata (data_in),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         addr_q     <= '0;
         err_q      <= 1'b0;
         data_out_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
         data_out_q <= data_out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = (accept_rd && (READ_LATENCY > 1)) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt_q == 3'd1) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      err_d      = err_q;
      data_out_d = data_out_q;
      if ((state_q == IDLE) && req) begin
         err_d  = !legal;
         addr_d = word_idx;
         cnt_d  = WAIT_CYCLES;
         if (accept_rd && (READ_LATENCY == 1)) begin
            data_out_d = rdata;
         end
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q - 3'd1;
         if (cnt_q == 3'd1) begin
            data_out_d = rdata;
         end
      end
   end

   always_comb begin
      data_out  = data_out_q;
      mem_ready = (state_q == RESP);
      addr_err  = (state_q == RESP) && err_q;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter READ_LATENCY, default 2, legal range 1..7, meaning cycles from read accept to mem_ready.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_addr  input  32  byte address from CPU data port.
REQ-006 SHALL have port data_in  input  32  write data from CPU.
REQ-007 SHALL have port mem_read  input  1  read request, held by CPU until mem_ready.
REQ-008 SHALL have port mem_write  input  1  write request, held by CPU until mem_ready.
REQ-009 SHALL have port data_out  output  32  registered read data.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port addr_err  output  1  one-cycle pulse for a rejected request.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP; requests are sampled only in IDLE.
REQ-013 SHALL treat a request as legal when exactly one of mem_read/mem_write is high, data_addr[1:0]==0 and data_addr[31:2] < DEPTH_WORDS.
REQ-014 SHALL, on an illegal request in IDLE (misaligned, out of range, or both strobes high), perform no memory access, leave data_out unchanged, pulse addr_err for the next cycle, and go to RESP.
REQ-015 SHALL write data_in to word data_addr[31:2] on the IDLE accept edge and go to RESP.
REQ-016 SHALL, on a legal read in IDLE, capture the word address; with READ_LATENCY==1, go directly to RESP; otherwise stay in WAIT for exactly READ_LATENCY-1 cycles, then go to RESP.
REQ-017 SHALL load data_out with the captured word on the edge entering RESP from a read; data_out holds until the next successful read.
REQ-018 SHALL assert mem_ready for exactly the one cycle spent in RESP, then return to IDLE; requests present during WAIT or RESP are ignored.
REQ-019 SHALL give mem_ready in the cycle following edge E0+(READ_LATENCY-1) for reads and following E0 for writes/errors, where E0 is the accept edge.
REQ-020 SHALL sustain one access per (READ_LATENCY+1) cycles for reads and per 2 cycles for writes with requests held continuously.
REQ-021 SHALL return for a read the memory value at the accept edge; no write can intervene because WAIT blocks acceptance.

Reset
REQ-022 SHALL, when rst is high at a clock edge, force state IDLE, data_out=0, mem_ready=0, addr_err=0, and clear the latency counter.
REQ-023 SHALL, on reset during WAIT or RESP, abort the access with no mem_ready pulse.
REQ-024 SHALL not clear memory contents on reset; a write accepted on the same edge that rst is high SHALL not occur.

Structure
REQ-025 SHALL take the FSM state enumeration and the DEPTH_WORDS/READ_LATENCY defaults from a shared package cpu_mem_pkg.
REQ-026 SHALL instantiate one sub-module dmem_array (synchronous write, combinational read, DEPTH_WORDS x 32) holding storage.

Verification
REQ-027 SHALL cover: write 0xDEADBEEF to 0x10, then read 0x10 with READ_LATENCY=2 -> mem_ready one cycle after write accept, read data_out=0xDEADBEEF with mem_ready 2 cycles after read accept.
REQ-028 SHALL cover: read of 0x13 (misaligned) -> addr_err=1 one cycle, mem_ready=1 one cycle, data_out unchanged, memory unchanged.
REQ-029 SHALL cover: mem_read and mem_write both high at 0x20 with data_in=0x1 -> addr_err pulse, word 0x20 unchanged; out-of-range address 0x400 (DEPTH_WORDS=256) -> addr_err pulse.
REQ-030 SHALL cover: rst asserted during WAIT of read at 0x10 -> no mem_ready, data_out=0, FSM IDLE next cycle; memory word 0x10 still 0xDEADBEEF.
REQ-031 SHALL cover: mem_read held high continuously at 0x10 with READ_LATENCY=1 -> mem_ready pulses every 2nd cycle, never two consecutive cycles.
REQ-032 SHALL cover: READ_LATENCY=7 read -> mem_ready exactly 7 cycles after accept; strobe changes during WAIT ignored.
